// File: rtl/register_file_sb.sv
// Multi-ported register file with write-through bypass, per-register pending-write
// scoreboard and a one-word-per-cycle clear sweep.
module register_file_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_READ   = 3,
  parameter int NUM_WRITE  = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  raddr_i,
  output logic [NUM_READ*DATA_WIDTH-1:0]  rdata_o,
  output logic [NUM_READ-1:0]             rbusy_o,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] waddr_i,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_WRITE-1:0]            we_i,
  input  logic                            rsv_i,
  input  logic [ADDR_WIDTH-1:0]           rsv_addr_i,
  input  logic                            clear_req_i,
  output logic                            clear_busy_o,
  output logic                            ready_o
);

  localparam int NUM_WORDS = 2 ** ADDR_WIDTH;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   ptr_reg;
  logic                    clear_busy_reg;
  logic                    ready_reg;
  logic [DATA_WIDTH-1:0]   regs_reg [NUM_WORDS];
  logic [NUM_WORDS-1:0]    busy_reg;

  logic [ADDR_WIDTH-1:0]   waddr [NUM_WRITE];
  logic [DATA_WIDTH-1:0]   wdata [NUM_WRITE];
  logic [NUM_WRITE-1:0]    wr_ok;
  logic                    rsv_ok;
  logic                    accept;

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  assign accept = (state_reg == IDLE);
  assign rsv_ok = accept && rsv_i && !is_zero(rsv_addr_i);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WRITE; gi++) begin : g_wport
      assign waddr[gi] = waddr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata[gi] = wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign wr_ok[gi] = accept && we_i[gi] && !is_zero(waddr[gi]);
    end
  endgenerate

  // Clear sweep control; outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      ptr_reg        <= '0;
      clear_busy_reg <= 1'b0;
      ready_reg      <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (clear_req_i) begin
            state_reg      <= CLEAR;
            ptr_reg        <= '0;
            clear_busy_reg <= 1'b1;
            ready_reg      <= 1'b0;
          end
        end
        CLEAR: begin
          ptr_reg <= ptr_reg + 1'b1;
          if (ptr_reg == {ADDR_WIDTH{1'b1}}) begin
            state_reg      <= IDLE;
            clear_busy_reg <= 1'b0;
            ready_reg      <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Later assignments override earlier ones: highest write port wins, reserve beats write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) regs_reg[i] <= '0;
      busy_reg <= '0;
    end else if (state_reg == CLEAR) begin
      regs_reg[ptr_reg] <= '0;
      busy_reg[ptr_reg] <= 1'b0;
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (wr_ok[j]) begin
          regs_reg[waddr[j]] <= wdata[j];
          busy_reg[waddr[j]] <= 1'b0;
        end
      end
      if (rsv_ok) busy_reg[rsv_addr_i] <= 1'b1;
    end
  end

  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_rport
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] rd_data;
      logic                  rd_busy;
      logic                  hit;

      assign ra = raddr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];

      always_comb begin
        rd_data = regs_reg[ra];
        hit     = 1'b0;
        if (BYPASS != 0) begin
          for (int j = 0; j < NUM_WRITE; j++) begin
            if (wr_ok[j] && (waddr[j] == ra)) begin
              hit     = 1'b1;
              rd_data = wdata[j];
            end
          end
        end
        // A bypassed write hides the busy bit unless a same-cycle reserve re-arms it.
        rd_busy = busy_reg[ra] && !(hit && !(rsv_ok && (rsv_addr_i == ra)));
        if (is_zero(ra)) begin
          rd_data = '0;
          rd_busy = 1'b0;
        end
      end

      assign rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = rd_data;
      assign rbusy_o[gi] = rd_busy;
    end
  endgenerate

  assign clear_busy_o = clear_busy_reg;
  assign ready_o      = ready_reg;

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: a driver pushes per-cycle expectations from an
// array-based reference model; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_register_file_sb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 3;
  localparam int NWP = 2;
  localparam int NWORDS = 2 ** AW;
  localparam int BYP = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR*AW-1:0]  raddr = '0;
  logic [NR*DW-1:0]  rdata;
  logic [NR-1:0]     rbusy;
  logic [NWP*AW-1:0] waddr = '0;
  logic [NWP*DW-1:0] wdata = '0;
  logic [NWP-1:0]    we = '0;
  logic              rsv = 1'b0;
  logic [AW-1:0]     rsv_addr = '0;
  logic              clear_req = 1'b0;
  logic              clear_busy;
  logic              ready;

  register_file_sb #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NWP),
    .ZERO_REG(1), .BYPASS(BYP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .rsv_i(rsv), .rsv_addr_i(rsv_addr),
    .clear_req_i(clear_req), .clear_busy_o(clear_busy), .ready_o(ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NR-1:0][DW-1:0] rdata;
    logic [NR-1:0]         rbusy;
    logic                  ready;
    logic                  cbusy;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // staged stimulus for the next cycle
  logic [AW-1:0] s_raddr [NR];
  logic [AW-1:0] s_waddr [NWP];
  logic [DW-1:0] s_wdata [NWP];
  logic          s_we    [NWP];
  logic          s_rsv;
  logic [AW-1:0] s_rsv_addr;
  logic          s_clr;

  // reference model
  logic [DW-1:0] m_mem  [NWORDS];
  logic          m_busy [NWORDS];
  int            clear_left;
  int            clear_ptr;

  task automatic model_reset();
    for (int i = 0; i < NWORDS; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    clear_left = 0;
    clear_ptr  = 0;
  endtask

  task automatic stage_idle();
    for (int k = 0; k < NR; k++) s_raddr[k] = '0;
    for (int j = 0; j < NWP; j++) begin
      s_waddr[j] = '0;
      s_wdata[j] = '0;
      s_we[j]    = 1'b0;
    end
    s_rsv = 1'b0; s_rsv_addr = '0; s_clr = 1'b0;
  endtask

  task automatic apply_inputs();
    for (int k = 0; k < NR; k++) raddr[k*AW +: AW] = s_raddr[k];
    for (int j = 0; j < NWP; j++) begin
      waddr[j*AW +: AW] = s_waddr[j];
      wdata[j*DW +: DW] = s_wdata[j];
      we[j]             = s_we[j];
    end
    rsv = s_rsv; rsv_addr = s_rsv_addr; clear_req = s_clr;
  endtask

  task automatic push_expect();
    exp_t e;
    bit   rdy;
    rdy = (clear_left == 0);
    for (int k = 0; k < NR; k++) begin
      logic [DW-1:0] d;
      bit hit;
      bit b;
      int a;
      a = int'(s_raddr[k]);
      d = m_mem[a];
      hit = 0;
      if (BYP != 0 && rdy)
        for (int j = 0; j < NWP; j++)
          if (s_we[j] && s_waddr[j] != 0 && int'(s_waddr[j]) == a) begin
            hit = 1; d = s_wdata[j];
          end
      b = m_busy[a] && !(hit && !(s_rsv && int'(s_rsv_addr) == a));
      if (a == 0) begin d = '0; b = 0; end
      e.rdata[k] = d;
      e.rbusy[k] = b;
    end
    e.ready = rdy;
    e.cbusy = !rdy;
    exp_q.push_back(e);
  endtask

  task automatic model_step();
    if (clear_left == 0) begin
      for (int j = 0; j < NWP; j++)
        if (s_we[j] && s_waddr[j] != 0) begin
          m_mem[s_waddr[j]]  = s_wdata[j];
          m_busy[s_waddr[j]] = 1'b0;
        end
      if (s_rsv && s_rsv_addr != 0) m_busy[s_rsv_addr] = 1'b1;
      if (s_clr) begin clear_left = NWORDS; clear_ptr = 0; end
    end else begin
      m_mem[clear_ptr]  = '0;
      m_busy[clear_ptr] = 1'b0;
      clear_ptr++;
      clear_left--;
    end
  endtask

  task automatic drive_cycle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply_inputs();
    push_expect();
    model_step();
    cyc++;
  endtask

  // Reset is asserted mid-cycle so the following negedge sample shows the async effect.
  task automatic reset_cycle();
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    apply_inputs();
    push_expect();
    cyc++;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int k = 0; k < NR; k++) begin
        checks++;
        if (rdata[k*DW +: DW] !== e.rdata[k]) begin
          errors++;
          $display("FAIL rdata[%0d] cyc %0d addr %0d: got %h want %h", k, cyc, raddr[k*AW +: AW], rdata[k*DW +: DW], e.rdata[k]);
        end
        checks++;
        if (rbusy[k] !== e.rbusy[k]) begin
          errors++;
          $display("FAIL rbusy[%0d] cyc %0d addr %0d: got %b want %b", k, cyc, raddr[k*AW +: AW], rbusy[k], e.rbusy[k]);
        end
      end
      checks++;
      if (ready !== e.ready) begin
        errors++;
        $display("FAIL ready cyc %0d: got %b want %b", cyc, ready, e.ready);
      end
      checks++;
      if (clear_busy !== e.cbusy) begin
        errors++;
        $display("FAIL clear_busy cyc %0d: got %b want %b", cyc, clear_busy, e.cbusy);
      end
    end
  end

  initial begin
    model_reset();
    stage_idle();
    s_raddr[0] = 5; s_raddr[1] = 7; s_raddr[2] = 9;
    reset_cycle();
    reset_cycle();

    // basic write then read
    stage_idle();
    s_we[0] = 1; s_waddr[0] = 5; s_wdata[0] = 32'hDEADBEEF;
    s_raddr[0] = 5; s_raddr[1] = 7;
    drive_cycle();
    stage_idle(); s_raddr[0] = 5; drive_cycle();

    // same-address collision, read in the same and next cycle
    stage_idle();
    s_we[0] = 1; s_waddr[0] = 7; s_wdata[0] = 32'h11;
    s_we[1] = 1; s_waddr[1] = 7; s_wdata[1] = 32'h22;
    s_raddr[0] = 7; s_raddr[2] = 7;
    drive_cycle();
    stage_idle(); s_raddr[1] = 7; drive_cycle();

    // scoreboard reserve / write / reserve+write on register 9
    stage_idle(); s_rsv = 1; s_rsv_addr = 9; s_raddr[0] = 9; drive_cycle();
    stage_idle(); s_raddr[0] = 9; drive_cycle();
    stage_idle(); s_we[1] = 1; s_waddr[1] = 9; s_wdata[1] = 32'h5; s_raddr[0] = 9; drive_cycle();
    stage_idle(); s_raddr[0] = 9; drive_cycle();
    stage_idle(); s_rsv = 1; s_rsv_addr = 9; s_we[0] = 1; s_waddr[0] = 9; s_wdata[0] = 32'hABCD;
    s_raddr[0] = 9; drive_cycle();
    stage_idle(); s_raddr[0] = 9; s_raddr[1] = 9; drive_cycle();

    // zero register
    stage_idle(); s_we[0] = 1; s_waddr[0] = 0; s_wdata[0] = 32'hFFFF_FFFF;
    s_rsv = 1; s_rsv_addr = 0; s_raddr[0] = 0; drive_cycle();
    stage_idle(); s_raddr[0] = 0; drive_cycle();

    // load regs 1..31 with their index, reserve a few, then sweep
    for (int a = 1; a < NWORDS; a += 2) begin
      stage_idle();
      s_we[0] = 1; s_waddr[0] = AW'(a); s_wdata[0] = a;
      if (a + 1 < NWORDS) begin s_we[1] = 1; s_waddr[1] = AW'(a + 1); s_wdata[1] = a + 1; end
      s_raddr[0] = AW'(a); s_raddr[1] = AW'(a - 1);
      drive_cycle();
    end
    stage_idle(); s_rsv = 1; s_rsv_addr = 4; s_raddr[0] = 3; drive_cycle();
    stage_idle(); s_rsv = 1; s_rsv_addr = 12; s_raddr[0] = 4; s_clr = 1; drive_cycle();
    for (int c = 0; c < NWORDS + 2; c++) begin
      stage_idle();
      s_we[0] = 1; s_waddr[0] = 3; s_wdata[0] = 32'h3333;
      s_rsv = 1; s_rsv_addr = 3;
      s_raddr[0] = 3; s_raddr[1] = 12; s_raddr[2] = AW'(c);
      drive_cycle();
    end
    for (int a = 0; a < NWORDS; a += NR) begin
      stage_idle();
      for (int k = 0; k < NR; k++) s_raddr[k] = AW'(a + k);
      drive_cycle();
    end

    // reset in the middle of a sweep
    for (int a = 1; a < 8; a++) begin
      stage_idle(); s_we[0] = 1; s_waddr[0] = AW'(a); s_wdata[0] = $urandom;
      s_rsv = 1; s_rsv_addr = AW'(a + 8); drive_cycle();
    end
    stage_idle(); s_clr = 1; drive_cycle();
    for (int c = 0; c < 10; c++) begin
      stage_idle(); s_raddr[0] = AW'(c); s_raddr[1] = AW'(c + 8); s_raddr[2] = 20; drive_cycle();
    end
    stage_idle(); s_raddr[0] = 12; s_raddr[1] = 15; s_raddr[2] = 10; reset_cycle();
    stage_idle(); s_raddr[0] = 12; s_raddr[1] = 5; drive_cycle();
    stage_idle(); drive_cycle();

    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      stage_idle();
      for (int k = 0; k < NR; k++)
        s_raddr[k] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      for (int j = 0; j < NWP; j++) begin
        s_we[j]    = $urandom_range(0, 1);
        s_waddr[j] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
        s_wdata[j] = $urandom;
      end
      s_rsv      = ($urandom_range(0, 2) == 0);
      s_rsv_addr = AW'($urandom_range(0, 7));
      s_clr      = ($urandom_range(0, 99) == 0);
      drive_cycle();
    end

    stage_idle();
    begin
      int waited;
      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
        @(posedge clk);
        waited++;
      end
      if (exp_q.size() > 0) begin
        errors++;
        $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
